// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default widths,
// the hard-wired zero register and write-port indices (lower index = lower priority).
package regfile_pkg;

    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned ZERO_REG = 0;

    localparam int unsigned WP_ALU   = 0;
    localparam int unsigned WP_MEM   = 1;
    localparam int unsigned NUM_WP   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, issue wins over
// a same-cycle clear. Provides raw pending lookup per read port and the global OR.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_en_i,
    input  logic [AW-1:0]        issue_rw_i,
    input  logic [NUM_WP-1:0]    clr_en_i,
    input  logic [NUM_WP*AW-1:0] clr_addr_i,
    input  logic [NUM_RD*AW-1:0] raddr_i,
    output logic [NUM_RD-1:0]    pend_o,
    output logic                 any_busy_o
);

    localparam int unsigned   DEPTH = 2**AW;
    localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Clears are applied before the set so a newly issued producer stays pending.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned w = 0; w < NUM_WP; w++) begin
            if (clr_en_i[w]) begin
                pend_d[clr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en_i && (issue_rw_i != ZADDR)) begin
            pend_d[issue_rw_i] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_o = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            pend_o[i] = pend_q[raddr_i[i*AW +: AW]];
        end
    end

    assign any_busy_o = |pend_q[DEPTH-1:1];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// write ports (memory port overrides ALU), optional write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_RD*AW-1:0] Raddr,
    output logic [NUM_RD*DW-1:0] Rdata,
    output logic [NUM_RD-1:0]    Rbusy,
    input  logic                 We0,
    input  logic [AW-1:0]        Rw0,
    input  logic [DW-1:0]        busW0,
    input  logic                 We1,
    input  logic [AW-1:0]        Rw1,
    input  logic [DW-1:0]        busW1,
    input  logic                 IssueEn,
    input  logic [AW-1:0]        IssueRw,
    output logic                 AnyBusy
);

    localparam int unsigned   DEPTH = 2**AW;
    localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);
    localparam bit            BYP   = (BYPASS != 0);

    logic [NUM_WP-1:0]    wr_req;
    logic [NUM_WP-1:0]    wr_commit;
    logic [AW-1:0]        wr_addr [NUM_WP];
    logic [DW-1:0]        wr_data [NUM_WP];
    logic [NUM_WP*AW-1:0] clr_addr;
    logic [NUM_RD-1:0]    pend_rd;
    logic [DW-1:0]        mem_q [DEPTH];
    logic [DW-1:0]        mem_d [DEPTH];

    always_comb begin
        wr_req[WP_ALU]  = We0 && (Rw0 != ZADDR);
        wr_addr[WP_ALU] = Rw0;
        wr_data[WP_ALU] = busW0;
        wr_req[WP_MEM]  = We1 && (Rw1 != ZADDR);
        wr_addr[WP_MEM] = Rw1;
        wr_data[WP_MEM] = busW1;
        wr_commit = wr_req;
        if (wr_req[WP_MEM] && (Rw0 == Rw1)) begin
            wr_commit[WP_ALU] = 1'b0;
        end
        clr_addr = '0;
        for (int unsigned w = 0; w < NUM_WP; w++) begin
            clr_addr[w*AW +: AW] = wr_addr[w];
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int unsigned w = 0; w < NUM_WP; w++) begin
            if (wr_commit[w]) begin
                mem_d[wr_addr[w]] = wr_data[w];
            end
        end
        mem_d[ZERO_REG] = '0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    regfile_scoreboard #(
        .AW     (AW),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .issue_en_i (IssueEn),
        .issue_rw_i (IssueRw),
        .clr_en_i   (wr_req),
        .clr_addr_i (clr_addr),
        .raddr_i    (Raddr),
        .pend_o     (pend_rd),
        .any_busy_o (AnyBusy)
    );

    // Outputs are forced to zero while Rst is high, even if a bypass would hit.
    always_comb begin
        Rdata = '0;
        Rbusy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] ra;
            logic          hit0;
            logic          hit1;
            ra   = Raddr[i*AW +: AW];
            hit1 = BYP && We1 && (Rw1 == ra);
            hit0 = BYP && We0 && (Rw0 == ra);
            if (!Rst && (ra != ZADDR)) begin
                if (hit1) begin
                    Rdata[i*DW +: DW] = busW1;
                end else if (hit0) begin
                    Rdata[i*DW +: DW] = busW0;
                end else begin
                    Rdata[i*DW +: DW] = mem_q[ra];
                end
                Rbusy[i] = pend_rd[i] && !(hit0 || hit1);
            end
        end
    end

endmodule
